// File: rtl/core_arb_pkg.sv
// Shared types and helpers for the N-core shared-memory arbiter.
package core_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // A core driving both strobes is treated as a write; its read strobe is masked.
  localparam bit WREN_WINS = 1'b1;

  function automatic int ptr_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/core_arb_rr_picker.sv
// Rotating-priority encoder: first requester after rr_ptr, wrapping modulo N_CORES.
module core_arb_rr_picker
  import core_arb_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int PTR_W   = ptr_w(N_CORES)
) (
  input  logic [N_CORES-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               valid
);

  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    // The last candidate examined is rr_ptr itself, so the previous winner has lowest priority.
    for (int i = 1; i <= N_CORES; i++) begin
      idx = (int'(rr_ptr) + i) % N_CORES;
      if (!valid && req[idx[PTR_W-1:0]]) begin
        winner = idx[PTR_W-1:0];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter granting one of N_CORES cores the single memory port.
// Define ARB_HOLD_LIMIT_EN to preempt an owner after MAX_HOLD owned cycles.
module core_mem_arbiter
  import core_arb_pkg::*;
#(
  parameter int N_CORES  = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CORES-1:0]         core_request,
  output logic [N_CORES-1:0]         core_enable,
  input  logic [N_CORES*ADDR_W-1:0]  core_addr,
  input  logic [N_CORES-1:0]         core_rden,
  input  logic [N_CORES-1:0]         core_wren,
  input  logic [N_CORES*DATA_W-1:0]  core_write_val,
  output logic [DATA_W-1:0]          core_read_val,
  output logic [N_CORES-1:0]         core_read_valid,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_rden,
  output logic                       mem_wren,
  output logic [DATA_W-1:0]          mem_write_val,
  input  logic [DATA_W-1:0]          mem_read_val,
  input  logic                       mem_ready
);

  localparam int PTR_W = ptr_w(N_CORES);

  if (N_CORES < 2 || N_CORES > 16 || MAX_HOLD < 1) begin : g_param_check
    $error("core_mem_arbiter: unsupported parameter set");
  end

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_CORES-1:0] enable_q, enable_d;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_vld;

  logic [N_CORES-1:0] own_onehot;
  logic [ADDR_W-1:0]  own_addr;
  logic [DATA_W-1:0]  own_wval;
  logic               own_req, own_rden, own_wren;
  logic               eff_rden, eff_wren;
  logic               owned, in_flight, preempt, release_now;

  core_arb_rr_picker #(
    .N_CORES (N_CORES),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req    (core_request),
    .rr_ptr (rr_ptr_q),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  // Owner channel select
  assign owned      = (state_q == OWNED);
  assign own_onehot = N_CORES'(1) << owner_q;
  assign own_req    = core_request[owner_q];
  assign own_rden   = core_rden[owner_q];
  assign own_wren   = core_wren[owner_q];
  assign own_addr   = core_addr[owner_q*ADDR_W +: ADDR_W];
  assign own_wval   = core_write_val[owner_q*DATA_W +: DATA_W];

  assign eff_wren   = own_wren & (WREN_WINS | ~own_rden);
  assign eff_rden   = own_rden & (~WREN_WINS | ~own_wren);

  // The raw strobes define the access in flight even when one of them is masked.
  assign in_flight   = own_rden | own_wren;
  assign release_now = (~own_req | preempt) & (~in_flight | mem_ready);

  assign mem_addr        = owned ? own_addr : '0;
  assign mem_write_val   = owned ? own_wval : '0;
  assign mem_rden        = owned & eff_rden;
  assign mem_wren        = owned & eff_wren;
  assign core_read_valid = (owned & eff_rden & mem_ready) ? own_onehot : '0;
  assign core_read_val   = mem_read_val;
  assign core_enable     = enable_q;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt_q;
  logic              others_req;

  assign others_req = |(core_request & ~own_onehot);
  assign preempt    = (hold_cnt_q == HOLD_W'(MAX_HOLD)) & others_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt_q <= '0;
    end else if (state_q == IDLE && pick_vld) begin
      hold_cnt_q <= '0;
    end else if (owned && hold_cnt_q != HOLD_W'(MAX_HOLD)) begin
      hold_cnt_q <= hold_cnt_q + 1'b1;
    end
  end
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    enable_d = enable_q;
    case (state_q)
      IDLE: begin
        enable_d = '0;
        if (pick_vld) begin
          state_d            = OWNED;
          owner_d            = pick_idx;
          rr_ptr_d           = pick_idx;
          enable_d[pick_idx] = 1'b1;
        end
      end
      OWNED: begin
        if (release_now) begin
          state_d  = RELEASE;
          enable_d = '0;
        end
      end
      RELEASE: begin
        state_d  = IDLE;
        enable_d = '0;
      end
      default: begin
        state_d  = IDLE;
        enable_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= PTR_W'(N_CORES - 1);
      enable_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      enable_q <= enable_d;
    end
  end

endmodule
